// File: rtl/pipe_pkg.sv
// Shared constants and state encoding for the ID-stage register scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int NREG     = 32;   // architectural registers, x0 never tracked
    localparam int RW       = 5;    // register index width, clog2(NREG)
    localparam int LONG_MAX = 64;   // watchdog limit for one MUL/DIV operation

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } sb_state_e;

endpackage

// File: rtl/sb_long_tracker.sv
// Occupancy FSM and watchdog for the single multi-cycle MUL/DIV unit.
// Latency: busy one cycle after issue, idle one cycle after long_done_i or watchdog expiry.
// Backpressure: none here; busy_o feeds the structural-hazard stall in the scoreboard.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_i         a long operation was accepted from ID this cycle
//   long_done_i     MUL/DIV result written back this cycle
//   busy_o          unit occupied (registered state)
//   timeout_o       sticky watchdog flag, cleared only by reset
//   timeout_hit_o   watchdog fires at the coming edge; used to flush pending bits
module sb_long_tracker #(
    parameter int LONG_MAX = pipe_pkg::LONG_MAX
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic long_done_i,
    output logic busy_o,
    output logic timeout_o,
    output logic timeout_hit_o
);
    import pipe_pkg::*;

    // Counter is wide enough to hold LONG_MAX itself so saturation is representable.
    localparam int CW = $clog2(LONG_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LONG_MAX - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(LONG_MAX);

    sb_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic          timeout_q;

    assign busy_o        = (state_q == SB_BUSY);
    assign timeout_o     = timeout_q;
    // Completion takes priority over the watchdog in the same cycle.
    assign timeout_hit_o = (state_q == SB_BUSY) && !long_done_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= SB_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                SB_IDLE: begin
                    // A completion seen while idle is stale and is ignored here.
                    if (start_i) begin
                        state_q <= SB_BUSY;
                        cnt_q   <= '0;
                    end
                end
                SB_BUSY: begin
                    if (long_done_i) begin
                        state_q <= SB_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= SB_IDLE;
                    end else if (cnt_q != CNT_SAT) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= SB_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage register scoreboard: stalls ID on load-use, pending MUL/DIV RAW/WAW and MUL/DIV busy.
// Latency: stall is combinational from registered state and ID inputs; tracking updates next edge.
// Backpressure: stall holds PC and IF/ID and inserts a bubble into ID/EX; flush overrides stall.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   id_*                            decoded fields of the instruction in ID
//   flush                           redirect; kills the ID instruction only
//   long_done, long_done_rd         MUL/DIV writeback and its destination
//   stall                           hazard stall towards IF/ID/EX
//   long_busy                       MUL/DIV occupied
//   pending                         registers awaiting MUL/DIV writeback (bit 0 always 0)
//   long_timeout                    sticky MUL/DIV watchdog flag
//   stall_cycles, lu_stalls         stall statistics, present only with SCOREBOARD_STATS_EN
module reg_scoreboard #(
    parameter int NREG     = pipe_pkg::NREG,
    parameter int RW       = pipe_pkg::RW,
    parameter int LONG_MAX = pipe_pkg::LONG_MAX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_regwrite,
    input  logic            id_is_load,
    input  logic            id_is_long,
    input  logic            flush,
    input  logic            long_done,
    input  logic [RW-1:0]   long_done_rd,
    output logic            stall,
    output logic            long_busy,
    output logic [NREG-1:0] pending,
    output logic            long_timeout
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     lu_stalls
`endif
);
    import pipe_pkg::*;

    logic [NREG-1:0] pending_q, pending_d;
    logic            ld_valid_q, ld_valid_d;
    logic [RW-1:0]   ld_rd_q, ld_rd_d;

    logic lu, raw, waw, st;
    logic accept, long_start, timeout_hit;

    // Hazard detection. Nothing here depends on long_done: a completing
    // operation releases its dependants one cycle later via pending_q/long_busy.
    assign lu  = ld_valid_q && (ld_rd_q != '0) &&
                 ((id_use_rs1 && (id_rs1 == ld_rd_q)) ||
                  (id_use_rs2 && (id_rs2 == ld_rd_q)));
    assign raw = (id_use_rs1 && pending_q[id_rs1]) ||
                 (id_use_rs2 && pending_q[id_rs2]);
    assign waw = id_regwrite && (id_rd != '0) && pending_q[id_rd];
    assign st  = id_is_long && long_busy;

    assign stall      = id_valid && !flush && (lu || raw || waw || st);
    assign accept     = id_valid && !stall && !flush;
    assign long_start = accept && id_is_long;

    assign pending = pending_q;

    sb_long_tracker #(
        .LONG_MAX (LONG_MAX)
    ) u_long_tracker (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (long_start),
        .long_done_i   (long_done),
        .busy_o        (long_busy),
        .timeout_o     (long_timeout),
        .timeout_hit_o (timeout_hit)
    );

    // Clear before set so a same-cycle set/clear on one index leaves it set.
    always_comb begin
        pending_d = pending_q;
        if (timeout_hit) begin
            pending_d = '0;
        end
        if (long_done) begin
            pending_d[long_done_rd] = 1'b0;
        end
        if (long_start && id_regwrite && (id_rd != '0)) begin
            pending_d[id_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    // A load is tracked only if it actually moves into EX; stalls and flushes
    // put a bubble there instead.
    always_comb begin
        ld_valid_d = accept && id_is_load && id_regwrite;
        ld_rd_d    = ld_valid_d ? id_rd : ld_rd_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q  <= '0;
            ld_valid_q <= 1'b0;
            ld_rd_q    <= '0;
        end else begin
            pending_q  <= pending_d;
            ld_valid_q <= ld_valid_d;
            ld_rd_q    <= ld_rd_d;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] lu_stalls_q;

    assign stall_cycles = stall_cycles_q;
    assign lu_stalls    = lu_stalls_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            lu_stalls_q    <= '0;
        end else begin
            if (stall) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (stall && lu) begin
                lu_stalls_q <= lu_stalls_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: per-scenario stimulus tables with an expected-result queue.
// Latency: inputs driven 1ns after posedge, outputs compared at negedge.
// Backpressure: n/a.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_is_load, id_is_long;
    logic [4:0]  id_rs1, id_rs2, id_rd, long_done_rd;
    logic        flush, long_done;
    logic        stall, long_busy, long_timeout;
    logic [31:0] pending;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles, lu_stalls;
`endif

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .id_rd        (id_rd),
        .id_regwrite  (id_regwrite),
        .id_is_load   (id_is_load),
        .id_is_long   (id_is_long),
        .flush        (flush),
        .long_done    (long_done),
        .long_done_rd (long_done_rd),
        .stall        (stall),
        .long_busy    (long_busy),
        .pending      (pending),
        .long_timeout (long_timeout)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .lu_stalls    (lu_stalls)
`endif
    );

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
        logic       lg;
        logic       fl;
        logic       dn;
        logic [4:0] drd;
    } stim_t;

    // Expected/observed word: {stall, long_busy, long_timeout, pending}
    logic [34:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    wire [34:0] obs = {stall, long_busy, long_timeout, pending};

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rd = rd; s.rw = 1'b1;
        s.rs1 = rs1; s.u1 = 1'b1; s.rs2 = rs2; s.u2 = 1'b1;
        return s;
    endfunction

    function automatic stim_t load(input logic [4:0] rd, input logic [4:0] rs1);
        stim_t s;
        s = '0;
        s.v = 1'b1; s.rd = rd; s.rw = 1'b1; s.ld = 1'b1;
        s.rs1 = rs1; s.u1 = 1'b1;
        return s;
    endfunction

    function automatic stim_t longop(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        stim_t s;
        s = alu(rd, rs1, rs2);
        s.lg = 1'b1;
        return s;
    endfunction

    function automatic logic [34:0] E(input bit st, input bit busy, input bit to, input logic [31:0] pend);
        return {st, busy, to, pend};
    endfunction

    function automatic logic [31:0] B(input int i);
        return 32'd1 << i;
    endfunction

    task automatic drive(input stim_t s);
        rst_n        = ~s.rst;
        id_valid     = s.v;
        id_rs1       = s.rs1;
        id_use_rs1   = s.u1;
        id_rs2       = s.rs2;
        id_use_rs2   = s.u2;
        id_rd        = s.rd;
        id_regwrite  = s.rw;
        id_is_load   = s.ld;
        id_is_long   = s.lg;
        flush        = s.fl;
        long_done    = s.dn;
        long_done_rd = s.drd;
    endtask

    task automatic test_reset();
        stim_t s;
        logic [34:0] e;
        s = idle();
        s.rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(i < 2 ? s : idle());
            exp_q.push_back(E(0, 0, 0, 32'h0));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset[%0d] {stall,busy,timeout,pending} got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [34:0] ex[$];
        logic [34:0] e;
        st.push_back(load(5, 1));   ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(alu(6, 5, 1)); ex.push_back(E(1, 0, 0, 32'h0));  // single bubble
        st.push_back(alu(6, 5, 1)); ex.push_back(E(0, 0, 0, 32'h0));  // ld tracking gone
        st.push_back(idle());       ex.push_back(E(0, 0, 0, 32'h0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL load_use[%0d] {stall,busy,timeout,pending} got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[$];
        logic [34:0] ex[$];
        logic [34:0] e;
        stim_t s;
        st.push_back(load(5, 1));   ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(load(7, 5));   ex.push_back(E(1, 0, 0, 32'h0));
        st.push_back(load(7, 5));   ex.push_back(E(0, 0, 0, 32'h0));  // accepted, now tracks x7
        st.push_back(alu(8, 1, 7)); ex.push_back(E(1, 0, 0, 32'h0));  // hazard via rs2
        st.push_back(alu(8, 1, 7)); ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(alu(9, 8, 7)); ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(load(10, 1));  ex.push_back(E(0, 0, 0, 32'h0));
        s = alu(11, 10, 10);
        s.u1 = 1'b0;
        s.u2 = 1'b0;
        st.push_back(s);            ex.push_back(E(0, 0, 0, 32'h0));  // operands not read
        st.push_back(idle());       ex.push_back(E(0, 0, 0, 32'h0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back[%0d] {stall,busy,timeout,pending} got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_long_raw();
        stim_t st[$];
        logic [34:0] ex[$];
        logic [34:0] e;
        stim_t s;
        st.push_back(longop(7, 1, 2)); ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(alu(8, 7, 2));    ex.push_back(E(1, 1, 0, B(7)));
        st.push_back(alu(8, 7, 2));    ex.push_back(E(1, 1, 0, B(7)));
        s = alu(8, 7, 2);
        s.dn = 1'b1;
        s.drd = 5'd7;
        st.push_back(s);               ex.push_back(E(1, 1, 0, B(7)));  // done does not unstall combinationally
        st.push_back(alu(8, 7, 2));    ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(idle());          ex.push_back(E(0, 0, 0, 32'h0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL long_raw[%0d] {stall,busy,timeout,pending} got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_struct_waw();
        stim_t st[$];
        logic [34:0] ex[$];
        logic [34:0] e;
        stim_t s;
        st.push_back(longop(9, 1, 2));  ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(longop(10, 1, 2)); ex.push_back(E(1, 1, 0, B(9)));  // structural
        st.push_back(alu(9, 1, 0));     ex.push_back(E(1, 1, 0, B(9)));  // waw
        s = alu(9, 1, 0);
        s.dn = 1'b1;
        s.drd = 5'd9;
        st.push_back(s);                ex.push_back(E(1, 1, 0, B(9)));
        st.push_back(alu(9, 1, 0));     ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(idle());           ex.push_back(E(0, 0, 0, 32'h0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL struct_waw[%0d] {stall,busy,timeout,pending} got %h exp %h", i, obs, e);
            end
        end
    endtask

    task automatic test_x0_flush();
        stim_t st[$];
        logic [34:0] ex[$];
        logic [34:0] e;
        stim_t s;
        st.push_back(load(0, 1));       ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(alu(6, 0, 0));     ex.push_back(E(0, 0, 0, 32'h0));  // x0 never hazards
        s = load(3, 1);
        s.fl = 1'b1;
        st.push_back(s);                ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(alu(6, 3, 3));     ex.push_back(E(0, 0, 0, 32'h0));  // flushed load not tracked
        st.push_back(longop(11, 1, 2)); ex.push_back(E(0, 0, 0, 32'h0));
        s = alu(6, 11, 1);
        s.fl = 1'b1;
        st.push_back(s);                ex.push_back(E(0, 1, 0, B(11)));  // flush masks stall only
        st.push_back(alu(6, 11, 1));    ex.push_back(E(1, 1, 0, B(11)));
        s = alu(6, 11, 1);
        s.dn = 1'b1;
        s.drd = 5'd11;
        st.push_back(s);                ex.push_back(E(1, 1, 0, B(11)));
        st.push_back(alu(6, 11, 1));    ex.push_back(E(0, 0, 0, 32'h0));
        s = longop(13, 1, 2);
        s.fl = 1'b1;
        st.push_back(s);                ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(idle());           ex.push_back(E(0, 0, 0, 32'h0));  // flushed long never issued
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL x0_flush[%0d] {stall,busy,timeout,pending} got %h exp %h", i, obs, e);
            end
        end
    endtask

    // Unit stays busy for 64 observed cycles after issue, then the watchdog fires.
    task automatic test_timeout();
        logic [34:0] e;
        stim_t s;
        for (int k = 0; k <= 68; k++) begin
            @(posedge clk); #1;
            s = (k == 0) ? longop(4, 1, 2) : idle();
            if (k == 67) begin
                s.dn = 1'b1;
                s.drd = 5'd4;
            end
            drive(s);
            if (k == 0)
                exp_q.push_back(E(0, 0, 0, 32'h0));
            else if (k <= 64)
                exp_q.push_back(E(0, 1, 0, B(4)));
            else
                exp_q.push_back(E(0, 0, 1, 32'h0));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout[%0d] {stall,busy,timeout,pending} got %h exp %h", k, obs, e);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        stim_t st[$];
        logic [34:0] ex[$];
        logic [34:0] e;
        stim_t s;
        st.push_back(longop(12, 1, 2)); ex.push_back(E(0, 0, 1, 32'h0));
        st.push_back(idle());           ex.push_back(E(0, 1, 1, B(12)));
        s = idle();
        s.rst = 1'b1;
        st.push_back(s);                ex.push_back(E(0, 1, 1, B(12)));  // reset not yet sampled
        st.push_back(idle());           ex.push_back(E(0, 0, 0, 32'h0));
        s = idle();
        s.dn = 1'b1;
        s.drd = 5'd12;
        st.push_back(s);                ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(alu(13, 12, 12));  ex.push_back(E(0, 0, 0, 32'h0));
        st.push_back(idle());           ex.push_back(E(0, 0, 0, 32'h0));
        foreach (st[i]) begin
            @(posedge clk); #1;
            drive(st[i]);
            exp_q.push_back(ex[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_op[%0d] {stall,busy,timeout,pending} got %h exp %h", i, obs, e);
            end
        end
    endtask

    initial begin
        stim_t s;
        s = idle();
        s.rst = 1'b1;
        drive(s);
        test_reset();
        test_load_use();
        test_back_to_back();
        test_long_raw();
        test_struct_waw();
        test_x0_flush();
        test_timeout();
        test_reset_mid_op();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d entries left exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
